// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// State encoding is fixed so other blocks and benches can decode it directly.
package serial_frame_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-index counter width; never collapse to zero bits for tiny frames.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// Parallel-in/serial-out frame serializer with valid/ready load and
// gapless back-to-back frames; the first bit appears on the accepting edge.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                          CP,
  input  logic                          RST,
  input  logic [WIDTH-1:0]              DIN,
  input  logic                          LOAD_VALID,
  output logic                          LOAD_READY,
  output logic                          D_OUT,
  output logic                          D_VALID,
  output logic                          LAST,
  output logic [cnt_width(WIDTH)-1:0]   BIT_CNT
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] din_ordered;
  logic             d_out_reg;
  logic             d_valid_reg;
  logic             last_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic             accept;

  // Normalise bit order so the shifter always emits from the top end.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_order
      assign din_ordered[gi] = MSB_FIRST ? DIN[gi] : DIN[WIDTH-1-gi];
    end
  endgenerate

  assign LOAD_READY = RST && ((state_reg == IDLE) || last_reg);
  assign accept     = LOAD_VALID && LOAD_READY;

  always_ff @(posedge CP) begin
    if (!RST) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      d_out_reg   <= IDLE_LEVEL;
      d_valid_reg <= 1'b0;
      last_reg    <= 1'b0;
    end else if (accept) begin
      // Fresh load from idle or chained on the final bit of a frame.
      state_reg   <= SHIFT;
      d_out_reg   <= din_ordered[WIDTH-1];
      shift_reg   <= {din_ordered[WIDTH-2:0], 1'b0};
      bit_cnt_reg <= '0;
      d_valid_reg <= 1'b1;
      last_reg    <= 1'b0;
    end else if (state_reg == SHIFT) begin
      if (!last_reg) begin
        d_out_reg   <= shift_reg[WIDTH-1];
        shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
        bit_cnt_reg <= bit_cnt_reg + CW'(1);
        last_reg    <= (bit_cnt_reg == PRE_LAST_IDX);
      end else begin
        state_reg   <= IDLE;
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
        d_out_reg   <= IDLE_LEVEL;
        d_valid_reg <= 1'b0;
        last_reg    <= 1'b0;
      end
    end
  end

  assign D_OUT   = d_out_reg;
  assign D_VALID = d_valid_reg;
  assign LAST    = last_reg;
  assign BIT_CNT = bit_cnt_reg;

endmodule
